// File: rtl/data_reg_mb_if.sv
// Bundle between the data register and its datapath/memory neighbours.
// Master drives the load requests and memory beats; slave is the register.
interface data_reg_mb_if #(
    parameter int BUS_W = 8,
    parameter int BEATS = 2
);
    localparam int DATA_W = BUS_W * BEATS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic              load_alu;
    logic              load_mem;
    logic [DATA_W-1:0] from_ALU;
    logic [BUS_W-1:0]  mem_bus;
    logic              mem_ack;
    logic              mem_req;
    logic [BEAT_W-1:0] mem_beat;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output load_alu, load_mem, from_ALU, mem_bus, mem_ack,
        input  mem_req, mem_beat, data, busy, done, err
    );

    modport slave (
        input  load_alu, load_mem, from_ALU, mem_bus, mem_ack,
        output mem_req, mem_beat, data, busy, done, err
    );
endinterface

// File: rtl/data_reg_mb.sv
// Data register: one-cycle ALU load or multi-beat memory fetch, atomic update.
// Latency: ALU load 1 edge; fetch BEATS edges after load_mem with ack held high.
// Backpressure: memory stalls via mem_ack=0 up to TIMEOUT cycles per beat; loads ignored while busy.
module data_reg_mb #(
    parameter int BUS_W   = 8,
    parameter int BEATS   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    data_reg_mb_if.slave bus
);
    localparam int DATA_W = BUS_W * BEATS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // The processor clocks its datapath state on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            buf_q   <= '0;
            wait_q  <= '0;
            beat_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            buf_q   <= buf_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        buf_d   = buf_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        req_d   = req_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.load_alu) begin
                    data_d = bus.from_ALU;
                    done_d = 1'b1;
                end else if (bus.load_mem) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    beat_d  = '0;
                    wait_d  = '0;
                    buf_d   = '0;
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    buf_d[beat_q*BUS_W +: BUS_W] = bus.mem_bus;
                    wait_d = '0;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        // Commit the whole word at once, final beat included.
                        data_d  = buf_d;
                        done_d  = 1'b1;
                        req_d   = 1'b0;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else if (wait_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data     = data_q;
    assign bus.mem_req  = req_q;
    assign bus.mem_beat = beat_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_data_reg_mb.sv
// Directed bench for data_reg_mb: stimulus queues expected done/err events,
// a monitor pops and compares them whenever the register pulses.
module tb_data_reg_mb;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    data_reg_mb_if #(.BUS_W(8), .BEATS(2)) bus ();

    data_reg_mb #(.BUS_W(8), .BEATS(2), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic        is_err;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Outputs move on the falling edge; everything is sampled/driven on the rising edge.
    task automatic step();
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        if (!rst && (bus.done || bus.err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b, expected none at %0t",
                         bus.done, bus.err, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {30'd0, bus.err, bus.done}, e.is_err ? 32'd2 : 32'd1);
                check("pulse_data", {16'd0, bus.data}, {16'd0, e.data});
            end
        end
    end

    initial begin
        bus.load_alu = 1'b0;
        bus.load_mem = 1'b0;
        bus.from_ALU = '0;
        bus.mem_bus  = '0;
        bus.mem_ack  = 1'b0;

        // 1. reset
        step(); step();
        rst = 1'b0;
        step();
        check("rst_data",    {16'd0, bus.data}, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_busy",    {31'd0, bus.busy}, 32'd0);
        check("rst_done",    {31'd0, bus.done}, 32'd0);
        check("rst_err",     {31'd0, bus.err}, 32'd0);

        // 2. ALU load
        bus.load_alu = 1'b1;
        bus.from_ALU = 16'hBEEF;
        exp_q.push_back('{is_err: 1'b0, data: 16'hBEEF});
        step();
        bus.load_alu = 1'b0;
        check("alu_busy", {31'd0, bus.busy}, 32'd0);
        check("alu_data", {16'd0, bus.data}, 32'h0000BEEF);
        step();
        check("alu_done_1cyc", {31'd0, bus.done}, 32'd0);

        // 3. two-beat fetch with ack high
        bus.load_mem = 1'b1;
        step();
        bus.load_mem = 1'b0;
        check("f3_req",  {31'd0, bus.mem_req}, 32'd1);
        check("f3_busy", {31'd0, bus.busy}, 32'd1);
        check("f3_beat0", {31'd0, bus.mem_beat}, 32'd0);
        bus.mem_ack = 1'b1;
        bus.mem_bus = 8'h34;
        step();
        check("f3_hold_data", {16'd0, bus.data}, 32'h0000BEEF);
        check("f3_beat1", {31'd0, bus.mem_beat}, 32'd1);
        bus.mem_bus = 8'h12;
        exp_q.push_back('{is_err: 1'b0, data: 16'h1234});
        step();
        bus.mem_ack = 1'b0;
        check("f3_req_fall", {31'd0, bus.mem_req}, 32'd0);
        check("f3_data", {16'd0, bus.data}, 32'h00001234);
        check("f3_busy_end", {31'd0, bus.busy}, 32'd0);

        // 4. timeout after one beat, then a clean fetch
        bus.load_mem = 1'b1;
        step();
        bus.load_mem = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_bus = 8'hAA;
        step();
        bus.mem_ack = 1'b0;
        exp_q.push_back('{is_err: 1'b1, data: 16'h1234});
        for (int i = 0; i < 14; i++) step();
        check("to_no_err_early", {31'd0, bus.err}, 32'd0);
        check("to_busy_early",   {31'd0, bus.busy}, 32'd1);
        step();
        check("to_busy", {31'd0, bus.busy}, 32'd0);
        check("to_req",  {31'd0, bus.mem_req}, 32'd0);
        check("to_data", {16'd0, bus.data}, 32'h00001234);
        step();
        check("to_err_1cyc", {31'd0, bus.err}, 32'd0);
        bus.load_mem = 1'b1;
        step();
        bus.load_mem = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_bus = 8'h01;
        step();
        bus.mem_bus = 8'h02;
        exp_q.push_back('{is_err: 1'b0, data: 16'h0201});
        step();
        bus.mem_ack = 1'b0;
        check("refetch_data", {16'd0, bus.data}, 32'h00000201);

        // 5. ALU wins over mem in IDLE; ALU ignored during FETCH
        bus.load_alu = 1'b1;
        bus.load_mem = 1'b1;
        bus.from_ALU = 16'h5A5A;
        exp_q.push_back('{is_err: 1'b0, data: 16'h5A5A});
        step();
        bus.load_alu = 1'b0;
        bus.load_mem = 1'b0;
        check("prio_req",  {31'd0, bus.mem_req}, 32'd0);
        check("prio_busy", {31'd0, bus.busy}, 32'd0);
        bus.load_mem = 1'b1;
        step();
        bus.load_mem = 1'b0;
        bus.load_alu = 1'b1;
        bus.from_ALU = 16'hFFFF;
        bus.mem_ack  = 1'b1;
        bus.mem_bus  = 8'hCD;
        step();
        check("fetch_alu_ignored", {16'd0, bus.data}, 32'h00005A5A);
        bus.mem_bus = 8'hAB;
        exp_q.push_back('{is_err: 1'b0, data: 16'hABCD});
        step();
        bus.load_alu = 1'b0;
        bus.mem_ack  = 1'b0;
        check("fetch_alu_data", {16'd0, bus.data}, 32'h0000ABCD);

        // 6. reset mid-fetch
        bus.load_mem = 1'b1;
        step();
        bus.load_mem = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_bus = 8'h77;
        step();
        bus.mem_ack = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_req",  {31'd0, bus.mem_req}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_data", {16'd0, bus.data}, 32'd0);
        check("mid_rst_beat", {31'd0, bus.mem_beat}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_err",  {31'd0, bus.err}, 32'd0);
        step(); step();
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
